dcache_mem_responder: RTL and testbench
=======================================

# dcache_mem_responder

Memory-side responder for the data cache's line interface: it services line-fill reads and dirty-line writebacks issued by the dcache datapath and controller. It holds a line-granular backing array, answers each request after a parameterised latency with a single-cycle acknowledge, and returns a full cache line on reads. It sits between the dcache/victim-cache subsystem and the top-level data memory, and serves as the synthesizable memory model in cache testbenches.

## Interface
- `ADDR_WIDTH`, 32, byte address width; matches the dcache address width.
- `LINE_WIDTH`, 128, line width in bits (4 × 32-bit words).
- `OFFSET_BITS`, 4, byte-offset bits within a line; ignored on input.
- `DEPTH_LINES`, 1024, array depth in lines; must be a power of two.
- `RD_LATENCY`, 4, cycles from request sample to read ack; range 1..15.
- `WR_LATENCY`, 4, cycles from request sample to write ack or drain; range 1..15.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dcache2mem_req_i`  in  1  request valid; held high until ack.
- `dcache2mem_wr_i`  in  1  1 = writeback, 0 = line fill; qualified by req.
- `dcache2mem_addr_i`  in  ADDR_WIDTH  line address; offset bits ignored.
- `dcache2mem_data_i`  in  LINE_WIDTH  writeback line.
- `mem2dcache_data_o`  out  LINE_WIDTH  read line; valid when ack is high on a read.
- `mem2dcache_ack_o`  out  1  one-cycle completion pulse.
- `mem_busy_o`  out  1  transaction in flight or posted write pending.

## Operation
- Index = `addr[OFFSET_BITS+log2(DEPTH_LINES)-1 : OFFSET_BITS]`.
  - Upper address bits are ignored.
  - Addresses alias modulo `DEPTH_LINES` lines.
- FSM states: IDLE, WAIT, RESP, GAP.
- IDLE:
  - On `req=1`, capture index, wr and data.
  - Load the counter with LAT−1, where LAT is `RD_LATENCY` or `WR_LATENCY`.
  - Go to WAIT, or directly to RESP if LAT = 1.
- WAIT:
  - Decrement the counter.
  - At 0, go to RESP.
  - The request inputs are not re-sampled.
- RESP:
  - Assert ack for exactly one cycle.
  - Write: commit the captured line to the array.
  - Read: drive the array line on `mem2dcache_data_o`.
  - Go to GAP.
- GAP:
  - One cycle; req is ignored so that the still-high req seen after ack is not re-served.
  - Go to IDLE.
- `mem2dcache_data_o` holds the last read line until the next read ack. It is unchanged on write acks.
- `mem_busy_o` = (state ≠ IDLE) | posted-buffer valid.
- Reset values:
  - state IDLE, ack 0, data_o 0, busy 0.
  - counter 0, posted buffer invalid.
  - Array contents are not reset.
- Reset mid-transaction: the transaction is abandoned; no ack and no array write occur.
- A read of a never-written line returns X in simulation. The bench writes lines before reading them.

## Timing
- Request sampled in cycle N → ack in cycle N+LAT.
- Next request sampled no earlier than N+LAT+2.
- Minimum spacing of back-to-back requests: LAT+2 cycles.
- A write is visible to a read whose RESP occurs in any later cycle.
- The ack pulse width is always 1. Ack never asserts while rst=1 or in the cycle after rst falls.

## Configuration
- Macro: `DMEM_POSTED_WR_EN`.
- Defined:
  - A write request is acked at N+1 and placed in a one-entry posted buffer (index, line).
  - The buffer drains to the array `WR_LATENCY` cycles after capture.
  - A new write while the buffer is valid stalls in IDLE (no capture) until the drain completes.
  - A read to the buffered index is served with the buffered line (forwarding), at normal `RD_LATENCY`.
  - A read to a different index proceeds concurrently with the drain.
  - Reset invalidates the buffer; an undrained write is lost.
- Undefined: writes follow the normal FSM with `WR_LATENCY`, and there is no buffer.

## Test plan
- Write then read:
  - Stimulus: write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to addr 0x0000_1230, then read 0x0000_123C.
  - Response: read data equals the written line; offset bits are ignored.
- Latency, with `RD_LATENCY`=4:
  - Stimulus: req sampled at cycle 10.
  - Response: ack only at cycle 14, width 1, followed by one GAP cycle with req still high and no second ack.
- Aliasing:
  - Stimulus: write line A to 0x0000_0000, write line B to 0x0000_4000 (DEPTH_LINES=1024), then read 0x0000_0000.
  - Response: the read returns B.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT of a write to 0x100, then read 0x100.
  - Response: no ack during reset; the read returns the old contents; busy=0 and data_o=0 right after reset.
- Posted write (`DMEM_POSTED_WR_EN`):
  - Stimulus: write C to 0x200, then read 0x200 immediately after its ack.
  - Response: the write is acked at N+1; the read returns C via forwarding; busy stays 1 until the drain completes.

Source files
------------

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: line-granular memory model serving dcache fills and writebacks after a fixed latency.
// Optional macro DMEM_POSTED_WR_EN: writes ack after one cycle and drain later from a one-entry posted buffer.
module dcache_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned OFFSET_BITS = 4,
    parameter int unsigned DEPTH_LINES = 1024,
    parameter int unsigned RD_LATENCY  = 4,
    parameter int unsigned WR_LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
    output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
    output logic                  mem2dcache_ack_o,
    output logic                  mem_busy_o
);
    localparam int unsigned IDX_W   = $clog2(DEPTH_LINES);
    localparam logic [3:0]  RD_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0]  WR_LOAD = 4'(WR_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_GAP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES];

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] rd_line;
    logic [IDX_W-1:0]      req_idx;
    logic [3:0]            lat_load;
    logic                  start_posted;
    logic                  start_normal;
    logic                  unused_addr_bits;

`ifdef DMEM_POSTED_WR_EN
    logic                  buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]      buf_idx_q, buf_idx_d;
    logic [3:0]            buf_cnt_q, buf_cnt_d;
`endif

    assign req_idx          = dcache2mem_addr_i[OFFSET_BITS +: IDX_W];
    assign unused_addr_bits = ^dcache2mem_addr_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        line_d    = line_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = line_q;
        lat_load  = dcache2mem_wr_i ? WR_LOAD : RD_LOAD;
`ifdef DMEM_POSTED_WR_EN
        buf_valid_d  = buf_valid_q;
        buf_idx_d    = buf_idx_q;
        buf_cnt_d    = buf_cnt_q;
        start_posted = dcache2mem_req_i & dcache2mem_wr_i & ~buf_valid_q;
        start_normal = dcache2mem_req_i & ~dcache2mem_wr_i;
        // line_q doubles as the posted line; it only changes on write capture.
        if (buf_valid_q) begin
            if (buf_cnt_q == '0) begin
                mem_we      = 1'b1;
                mem_widx    = buf_idx_q;
                mem_wdata   = line_q;
                buf_valid_d = 1'b0;
            end else begin
                buf_cnt_d = buf_cnt_q - 4'd1;
            end
        end
`else
        start_posted = 1'b0;
        start_normal = dcache2mem_req_i;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_posted) begin
                    idx_d   = req_idx;
                    wr_d    = 1'b1;
                    line_d  = dcache2mem_data_i;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (start_normal) begin
                    idx_d = req_idx;
                    wr_d  = dcache2mem_wr_i;
                    cnt_d = lat_load;
                    if (dcache2mem_wr_i) begin
                        line_d = dcache2mem_data_i;
                    end
                    state_d = (lat_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_GAP;
`ifndef DMEM_POSTED_WR_EN
                mem_we = wr_q;
`endif
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef DMEM_POSTED_WR_EN
        if (state_q == ST_IDLE && start_posted) begin
            buf_valid_d = 1'b1;
            buf_idx_d   = req_idx;
            buf_cnt_d   = WR_LOAD;
        end
        rd_line = (buf_valid_q && buf_idx_q == idx_d) ? line_q : mem_q[idx_d];
`else
        rd_line = mem_q[idx_d];
`endif
        // Read data is latched on entry to RESP so it is stable for the whole ack cycle.
        if (state_d == ST_RESP && !wr_d) begin
            rdata_d = rd_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_POSTED_WR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_cnt_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_cnt_q   <= buf_cnt_d;
        end
    end

    assign mem_busy_o = (state_q != ST_IDLE) | buf_valid_q;
`else
    assign mem_busy_o = (state_q != ST_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign mem2dcache_ack_o  = (state_q == ST_RESP) && !rst;
    assign mem2dcache_data_o = rdata_q;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed self-checking bench for dcache_mem_responder (default parameters, either build of DMEM_POSTED_WR_EN).
module tb_dcache_mem_responder;
    localparam int unsigned RLAT = 4;
`ifdef DMEM_POSTED_WR_EN
    localparam int unsigned WLAT = 1;
`else
    localparam int unsigned WLAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] data_o;
    logic         ack;
    logic         busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] LX = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [127:0] LA = 128'hAAAA_0000_AAAA_1111_AAAA_2222_AAAA_3333;
    localparam logic [127:0] LB = 128'hBBBB_4444_BBBB_5555_BBBB_6666_BBBB_7777;
    localparam logic [127:0] D0 = 128'h0000_0100_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D1 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    localparam logic [127:0] LC = 128'hC0C0_C1C1_C2C2_C3C3_C4C4_C5C5_C6C6_C7C7;

    dcache_mem_responder #(
        .ADDR_WIDTH (32),
        .LINE_WIDTH (128),
        .OFFSET_BITS(4),
        .DEPTH_LINES(1024),
        .RD_LATENCY (4),
        .WR_LATENCY (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dcache2mem_req_i (req),
        .dcache2mem_wr_i  (wr),
        .dcache2mem_addr_i(addr),
        .dcache2mem_data_i(wdata),
        .mem2dcache_data_o(data_o),
        .mem2dcache_ack_o (ack),
        .mem_busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic xact(input logic w, input logic [31:0] a, input logic [127:0] d,
                        input int unsigned lat, input string tag, output logic [127:0] rd);
        int unsigned first;
        int unsigned n;
        first = 0;
        n     = 0;
        rd    = '0;
        wr    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        @(posedge clk);
        for (int unsigned k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy"}, busy, 1'b1);
            if (ack) begin
                n++;
                if (first == 0) begin
                    first = k;
                    rd    = data_o;
                end
            end
            if (k == lat + 2) req = 1'b0;
        end
        chk({tag, "_lat"}, first, lat);
        chk({tag, "_acks"}, n, 1);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rd;
        rst   = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data_o, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", ack, 1'b0);

        // Write then read with different offset bits.
        xact(1'b1, 32'h0000_1230, L1, WLAT, "wr_l1", rd);
        xact(1'b0, 32'h0000_123C, '0, RLAT, "rd_l1", rd);
        chk("rd_l1_data", rd, L1);

        // Output holds the last read line across a write ack.
        wait_idle();
        xact(1'b1, 32'h0000_0500, LX, WLAT, "wr_lx", rd);
        chk("hold_on_wr", data_o, L1);

        // Aliasing modulo 1024 lines.
        wait_idle();
        xact(1'b1, 32'h0000_0000, LA, WLAT, "wr_a", rd);
        wait_idle();
        xact(1'b1, 32'h0000_4000, LB, WLAT, "wr_b", rd);
        wait_idle();
        xact(1'b0, 32'h0000_0000, '0, RLAT, "rd_alias", rd);
        chk("rd_alias_data", rd, LB);
        xact(1'b0, 32'h0000_1238, '0, RLAT, "rd_l1b", rd);
        chk("rd_l1b_data", rd, L1);

        // Reset while a write to 0x100 is in flight.
        wait_idle();
        xact(1'b1, 32'h0000_0100, D0, WLAT, "wr_d0", rd);
        wait_idle();
        wr    = 1'b1;
        addr  = 32'h0000_0100;
        wdata = D1;
        req   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        #1 chk("ack_rst_edge", ack, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ack_in_rst", ack, 1'b0);
            chk("busy_in_rst", busy, 1'b0);
        end
        chk("data_in_rst", data_o, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("ack_after_rst", ack, 1'b0);
        chk("busy_after_rst", busy, 1'b0);
        chk("data_after_rst", data_o, '0);
        repeat (4) @(negedge clk);
        xact(1'b0, 32'h0000_0100, '0, RLAT, "rd_d0", rd);
        chk("rd_d0_data", rd, D0);

`ifdef DMEM_POSTED_WR_EN
        // Posted write followed immediately by a read of the same line.
        wait_idle();
        xact(1'b1, 32'h0000_0200, LC, 1, "wr_c", rd);
        chk("busy_pending", busy, 1'b1);
        xact(1'b0, 32'h0000_0200, '0, RLAT, "rd_c", rd);
        chk("rd_c_data", rd, LC);
        chk("busy_drained", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
